// File: rtl/countdown_timer_7seg.sv
// MM:SS countdown timer (00:00-99:59) on the 4-digit multiplexed 7-segment display, button-controlled.
// Latency: button pulse ~DEBOUNCE_CYCLES+3 after a clean press; digits update 1 cycle after pulse/tick; an/seg 1 cycle later.
// Backpressure: none; button pulses are gated (dropped) while mode=1, display scans freely.
module countdown_timer_7seg #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_CYCLES  = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       mode,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PSW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RFW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  // Button bit order throughout: {u, r, l, c}
  logic [3:0]     raw;
  logic [3:0]     sync1, sync2, stable, stable_q;
  logic [DBW-1:0] db_cnt [4];
  logic [3:0]     pulse;
  logic           pc, pl, pr, pu;

  logic [3:0]     mt, mo, st, so;
  logic           running;
  logic [PSW-1:0] pre;
  logic           tick, time_zero, time_one;

  logic [RFW-1:0] ref_cnt;
  logic [1:0]     scan_idx;
  logic [3:0]     cur_digit;

  assign raw = {btn_u, btn_r, btn_l, btn_c};

  // Synchronize each button, then accept a new level only after it differs from the accepted one for DEBOUNCE_CYCLES samples in a row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edges of the accepted levels; the buttons belong to other logic while mode is high
  assign pulse = stable & ~stable_q & {4{~mode}};
  assign pc    = pulse[0];
  assign pl    = pulse[1];
  assign pr    = pulse[2];
  assign pu    = pulse[3];

  assign tick      = running && (pre == PSW'(CLK_HZ - 1));
  assign time_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
  assign time_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

  // Time digits, running flag and 1-second prescaler; priority clear > minute adjust > start/stop > tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mt <= 4'd0; mo <= 4'd0; st <= 4'd0; so <= 4'd0;
      running <= 1'b0;
      pre     <= '0;
    end else begin
      // Minute adjust leaves the prescaler running; a tick that collides with it is dropped
      if (running && !tick) pre <= pre + 1'b1;
      else                  pre <= '0;

      if (pu) begin
        mt <= 4'd0; mo <= 4'd0; st <= 4'd0; so <= 4'd0;
        running <= 1'b0;
        pre     <= '0;
      end else if (pl || pr) begin
        if (pr && !pl) begin
          if (mt == 4'd9 && mo == 4'd9) begin
            st <= 4'd5; so <= 4'd9;
          end else if (mo == 4'd9) begin
            mo <= 4'd0; mt <= mt + 4'd1;
          end else begin
            mo <= mo + 4'd1;
          end
        end else if (pl && !pr) begin
          if (mt == 4'd0 && mo == 4'd0) begin
            st <= 4'd0; so <= 4'd0;
          end else if (mo == 4'd0) begin
            mo <= 4'd9; mt <= mt - 4'd1;
          end else begin
            mo <= mo - 4'd1;
          end
        end
      end else if (pc) begin
        if (running) begin
          running <= 1'b0;
          pre     <= '0;
        end else if (!time_zero) begin
          running <= 1'b1;
          pre     <= '0;
        end
      end else if (tick) begin
        // Minutes may have been taken to 00:00 while running; just stop there
        if (time_zero || time_one) running <= 1'b0;
        if (!time_zero) begin
          if (so != 4'd0) so <= so - 4'd1;
          else begin
            so <= 4'd9;
            if (st != 4'd0) st <= st - 4'd1;
            else begin
              st <= 4'd5;
              if (mo != 4'd0) mo <= mo - 4'd1;
              else begin
                mo <= 4'd9;
                mt <= mt - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Digit scan: hold each digit for REFRESH_CYCLES then move to the next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt  <= '0;
      scan_idx <= 2'd0;
    end else if (ref_cnt == RFW'(REFRESH_CYCLES - 1)) begin
      ref_cnt  <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Select the digit under the current scan position
  always_comb begin
    cur_digit = so;
    case (scan_idx)
      2'd0: cur_digit = so;
      2'd1: cur_digit = st;
      2'd2: cur_digit = mo;
      2'd3: cur_digit = mt;
      default: cur_digit = so;
    endcase
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;
      4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;
      4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;
      4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;
      4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Registered anode/cathode drive so the pins never glitch between digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= ~(4'b0001 << scan_idx);
      seg <= seg_of(cur_digit);
    end
  end

endmodule

// File: tb/tb_countdown_timer_7seg.sv
// Bench for countdown_timer_7seg with small parameters; expected MM:SS values queued on stimulus,
// popped when the display is decoded from a full anode scan.
module tb_countdown_timer_7seg;

  localparam int CLK_HZ = 100;
  localparam int DEB    = 4;
  localparam int REF    = 8;

  // Button masks {u, r, l, c}
  localparam logic [3:0] B_C = 4'b0001;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_R = 4'b0100;
  localparam logic [3:0] B_U = 4'b1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];
  logic [10:0] scan_q [$];

  always #5 clk = ~clk;

  countdown_timer_7seg #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .reset(reset),
    .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u),
    .mode(mode), .an(an), .seg(seg)
  );

  function automatic logic [3:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    {btn_u, btn_r, btn_l, btn_c} = m;
    cyc(20);
    {btn_u, btn_r, btn_l, btn_c} = 4'b0000;
    cyc(20);
  endtask

  // Collect one full scan of the display as BCD {MT,MO,ST,SO}
  task automatic read_display(output logic [15:0] val);
    logic [3:0] seen;
    int n;
    seen = 4'b0000;
    val  = 16'hFFFF;
    n    = 0;
    while (seen != 4'hF && n < 80) begin
      @(negedge clk);
      n++;
      case (an)
        4'b1110: begin val[3:0]   = dec(seg); seen[0] = 1'b1; end
        4'b1101: begin val[7:4]   = dec(seg); seen[1] = 1'b1; end
        4'b1011: begin val[11:8]  = dec(seg); seen[2] = 1'b1; end
        4'b0111: begin val[15:12] = dec(seg); seen[3] = 1'b1; end
        default: ;
      endcase
    end
    if (seen != 4'hF) begin
      n_vec++;
      n_bad++;
      $display("FAIL display_scan_timeout: digits seen %b, required 1111 within 80 cycles", seen);
    end
  endtask

  task automatic test_reset();
    logic [10:0] e;
    cyc(3);
    scan_q.push_back({4'b1110, 7'b1000000});
    e = scan_q.pop_front();
    n_vec++;
    if ({an, seg} !== e) begin
      n_bad++;
      $display("FAIL reset_outputs: an/seg %b/%b, required %b/%b", an, seg, e[10:7], e[6:0]);
    end
    scan_q.push_back({4'b1110, 7'b1000000});
    scan_q.push_back({4'b1101, 7'b1000000});
    scan_q.push_back({4'b1011, 7'b1000000});
    scan_q.push_back({4'b0111, 7'b1000000});
    scan_q.push_back({4'b1110, 7'b1000000});
    reset = 1'b0;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      e = scan_q.pop_front();
      n_vec++;
      if ({an, seg} !== e) begin
        n_bad++;
        $display("FAIL scan_%0d: an/seg %b/%b, required %b/%b", i, an, seg, e[10:7], e[6:0]);
      end
      cyc(8);
    end
  endtask

  task automatic test_set_minutes();
    logic [3:0]  ops  [4] = '{B_R, B_L, B_L | B_R, B_L};
    int          reps [4] = '{3, 1, 1, 3};
    logic [15:0] want [4] = '{16'h0300, 16'h0200, 16'h0200, 16'h0000};
    logic [15:0] got, e;
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < reps[s]; r++) press(ops[s]);
      exp_q.push_back(want[s]);
      read_display(got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL set_step%0d: display %h, required %h", s, got, e);
      end
    end
  endtask

  task automatic test_countdown();
    logic [15:0] got, e;
    press(B_R);
    press(B_C);
    exp_q.push_back(16'h0100);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL cd_start: display %h, required %h", got, e); end
    cyc(70);
    exp_q.push_back(16'h0059);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL cd_first_tick: display %h, required %h", got, e); end
    cyc(6000);
    exp_q.push_back(16'h0000);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL cd_expire: display %h, required %h", got, e); end
    // Running must have dropped at 00:00: a new minute must stay put
    press(B_R);
    cyc(300);
    exp_q.push_back(16'h0100);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL cd_stopped_after_zero: display %h, required %h", got, e); end
    // Start from 00:00 is ignored
    press(B_U);
    press(B_C);
    press(B_R);
    cyc(300);
    exp_q.push_back(16'h0100);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL cd_start_at_zero: display %h, required %h", got, e); end
    press(B_U);
  endtask

  task automatic test_saturate_and_mode();
    logic [3:0]  mops [4] = '{B_R, B_L, B_C, B_U};
    logic [15:0] got, e;
    for (int i = 0; i < 99; i++) press(B_R);
    exp_q.push_back(16'h9900);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL sat_99: display %h, required %h", got, e); end
    for (int i = 0; i < 2; i++) begin
      press(B_R);
      exp_q.push_back(16'h9959);
      read_display(got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL sat_9959_%0d: display %h, required %h", i, got, e); end
    end
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press(mops[i]);
      cyc(200);
      exp_q.push_back(16'h9959);
      read_display(got);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin n_bad++; $display("FAIL mode_gate_%0d: display %h, required %h", i, got, e); end
    end
    mode = 1'b0;
    press(B_L);
    exp_q.push_back(16'h9859);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL sub_keeps_secs: display %h, required %h", got, e); end
    press(B_U);
    exp_q.push_back(16'h0000);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL clear_after_mode: display %h, required %h", got, e); end
  endtask

  task automatic test_bounce();
    logic [15:0] got, e;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      btn_r = ~btn_r;
      cyc(2);
    end
    cyc(20);
    btn_r = 1'b0;
    cyc(20);
    exp_q.push_back(16'h0100);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL bounce_one_pulse: display %h, required %h", got, e); end
    press(B_U);
  endtask

  task automatic test_clear_running();
    logic [15:0] got, e;
    for (int i = 0; i < 6; i++) press(B_R);
    press(B_C);
    cyc(2980);
    exp_q.push_back(16'h0530);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL run_0530: display %h, required %h", got, e); end
    press(B_U);
    cyc(300);
    exp_q.push_back(16'h0000);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL clear_while_running: display %h, required %h", got, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] got, e;
    logic [10:0] se;
    int n;
    for (int i = 0; i < 3; i++) press(B_R);
    press(B_C);
    cyc(4980);
    exp_q.push_back(16'h0210);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL run_0210: display %h, required %h", got, e); end
    // Assert reset while the minutes-ones digit (2) is shown, away from any clock edge
    n = 0;
    while (an !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    scan_q.push_back({4'b1110, 7'b1000000});
    se = scan_q.pop_front();
    n_vec++;
    if ({an, seg} !== se) begin
      n_bad++;
      $display("FAIL async_reset: an/seg %b/%b, required %b/%b", an, seg, se[10:7], se[6:0]);
    end
    cyc(3);
    reset = 1'b0;
    exp_q.push_back(16'h0000);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL after_reset: display %h, required %h", got, e); end
    press(B_R);
    cyc(300);
    exp_q.push_back(16'h0100);
    read_display(got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_stops_run: display %h, required %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_set_minutes();
    test_countdown();
    test_saturate_and_mode();
    test_bounce();
    test_clear_running();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_7seg.md
# countdown_timer_7seg

Minute/second countdown timer driving the 4-digit multiplexed 7-segment display of the Basys 3 board. Four push buttons set, start/stop and clear an MM:SS value (00:00–99:59) that counts down once per second while running. A mode input hands the buttons to other logic (the VGA tally counter) by gating all timer button actions. Sits at top level beside the VGA text path, sharing the raw buttons.

## Interface
- CLK_HZ, 100_000_000: clock cycles per 1-second tick.
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must stay unchanged to be accepted.
- REFRESH_CYCLES, 100_000: cycles each digit is driven before the scan advances.
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high; clock clk.
- btn_c  in  1  start/stop toggle (raw, bouncy).
- btn_l  in  1  subtract 1 minute (raw).
- btn_r  in  1  add 1 minute (raw).
- btn_u  in  1  clear to 00:00 and stop (raw).
- mode  in  1  0 = timer owns buttons; 1 = all timer button actions ignored.
- an  out  4  active-low digit anodes; an[0] = seconds ones … an[3] = minutes tens.
- seg  out  7  active-low cathodes, seg[0]=a … seg[6]=g.

## Operation
- Per button: 2-FF synchronizer, then debounce counter; accepted level updates only after DEBOUNCE_CYCLES consecutive equal samples; rising edge of accepted level gives a 1-cycle pulse. Pulses discarded while mode=1 (sampled same cycle).
- Time held as four BCD digits MT, MO, ST, SO (MT,MO,SO 0–9; ST 0–5); running flag.
- Priority per cycle: btn_u > (btn_l/btn_r) > btn_c > second tick.
- btn_u: digits := 00:00, running := 0, prescaler := 0.
- btn_r alone: minutes +1; if minutes already 99 → saturate to 99:59. Seconds kept otherwise.
- btn_l alone: minutes −1 if minutes ≥1; if minutes 0 → 00:00. Seconds kept when minutes ≥1.
- btn_l and btn_r same cycle: no change.
- btn_c: if running → running := 0; else if time ≠ 00:00 → running := 1 and prescaler := 0; else ignored.
- Buttons L/R allowed while running; they do not alter running or prescaler.
- Prescaler counts 0..CLK_HZ−1 while running; on wrap emits tick: BCD decrement (SO borrow to ST 5, ST to MO 9, MO to MT); if result 00:00 → running := 0. Prescaler held at 0 when stopped.
- mode does not affect counting or display.
- Display: scan index 0..3, advances every REFRESH_CYCLES; an = one-hot-low of index; seg = pattern of selected digit. Patterns (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. No leading-zero blanking.

## Timing
- Reset (async): digits 00:00, running 0, prescaler 0, scan index 0, debounce states 0, an=1110, seg=1000000.
- an/seg registered; change 1 cycle after scan index / digit update.
- Button pulse occurs DEBOUNCE_CYCLES+3 cycles (±1) after a clean input rise; releases produce no pulse; press held indefinitely = one pulse.
- Time digits update the cycle after the pulse/tick.
- First tick after start: exactly CLK_HZ cycles after the start-pulse cycle; subsequent every CLK_HZ.
- Stop mid-second discards partial second.
- Reset mid-operation aborts everything immediately; pulses pending in the debouncer are lost.

## Test plan
(Sim parameters: CLK_HZ=100, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8.)
- Reset → an=1110, seg=1000000; scan visits an 1110,1101,1011,0111 every 8 cycles, all showing 0.
- btn_r pressed 3× (each held 20 cycles), mode=0 → 03:00; btn_l once → 02:00; btn_l 3× → 00:00 (floor).
- Set 01:00, btn_c → after 100 cycles 00:59; after 6000 total cycles 00:00 and running cleared; further btn_c from 00:00 ignored.
- Set 99:00, btn_r → 99:59; mode=1 then btn_r/btn_l/btn_c/btn_u → no change.
- Bouncy btn_r (toggling every 2 cycles for 30 cycles, then stable high) → exactly one +1 minute.
- Running at 05:30, btn_u → 00:00 stopped; running at 02:10, assert reset → 00:00, an=1110 immediately.
